kbd_event_sched: RTL and testbench
==================================

KBD_EVENT_SCHED -- requirements
Module: kbd_event_sched

Interface
REQ-001 Parameter FIFO_DEPTH, default 8, event queue depth; power of two, 2..16.
REQ-002 clk_sys  input  1  system clock; all logic rising-edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 ps2_key  input  11  bit10 toggles per PS/2 event, bit9 = pressed, bits8:0 = scan code (bit8 = extended).
REQ-005 joy_numpad  input  10  level, bit i high = pad key i held; bits 0..8 = "1".."9", bit 9 = "0".
REQ-006 rx_data_ready_o  output  1  head event valid toward keymap.
REQ-007 rx_ascii_o  output  8  head event character code.
REQ-008 rx_released_o  output  1  head event is a release.
REQ-009 rx_read_i  input  1  keymap consumed head event (single-cycle pulse).
REQ-010 overflow_o  output  1  sticky: an event was dropped because the queue was full.
REQ-011 level_o  output  5  current queue occupancy.

Function
REQ-012 PS/2 event detected when ps2_key[10] differs from its value registered the previous cycle.
REQ-013 Translation ignores bit8. Map: 0x16,1E,26,25,2E,36,3D,3E,46,45 -> "1".."9","0"; letters a-z by set-2 codes; 0x29 " "; 0x79 "+"; 0x7B "-"; 0x7C "*"; 0x4A "/"; 0x55 "="; 0x1F 0x11; 0x27 0x12; 0x5A 0x0A; 0x66 0x08.
REQ-014 Unmapped scan codes produce no event.
REQ-015 Queued PS/2 event = {released = ~ps2_key[9], ascii}.
REQ-016 Joystick: each cycle, changed = joy_numpad XOR previous registered value; changed bits OR into a 10-bit pending mask.
REQ-017 Pending joystick bits are serviced one per cycle, lowest index first; the event is {released = ~joy_numpad[i], ascii of bit i}; bit i is cleared when enqueued.
REQ-018 When the pad bit toggles twice before service, the event reflects the current level; pending remains set until serviced.
REQ-019 Enqueue at most one event per cycle; a PS/2 event has priority over joystick and is never delayed; a joystick event waits while a PS/2 event is enqueuing.
REQ-020 Queue full at enqueue -> event discarded, overflow_o set, queue unchanged; for joystick the pending bit is still cleared.
REQ-021 Output FSM states IDLE, PRESENT, GAP.
REQ-022 IDLE: rx_data_ready_o = 0; queue non-empty -> PRESENT next cycle.
REQ-023 PRESENT: rx_data_ready_o = 1 and rx_ascii_o/rx_released_o = head, stable; rx_read_i = 1 -> pop head, go to GAP.
REQ-024 GAP: rx_data_ready_o = 0 for exactly one cycle, then IDLE.
REQ-025 rx_read_i outside PRESENT is ignored.
REQ-026 Simultaneous enqueue and pop in the same cycle are both performed; level_o remains unchanged.
REQ-027 Enqueue to empty queue -> rx_data_ready_o high no earlier than 2 cycles after the detect cycle; FIFO order is preserved.
REQ-028 Read/write pointers wrap modulo FIFO_DEPTH; level_o = count of entries, 0..FIFO_DEPTH.

Reset
REQ-029 Reset clears the queue, pointers, pending mask, and overflow_o, and puts the FSM in IDLE.
REQ-030 Reset loads the previous-value registers from the current ps2_key[10] and joy_numpad so no spurious event follows reset.
REQ-031 Outputs during and after reset: rx_data_ready_o 0, rx_ascii_o 0x00, rx_released_o 0, overflow_o 0, level_o 0.
REQ-032 Reset mid-PRESENT abandons the head event without a pop handshake.

Structure
REQ-033 A shared package vp_kbd_pkg holds the event struct {released, ascii[7:0]}, the FSM state enum, and the ASCII constants 0x11, 0x12, 0x0A, 0x08.
REQ-034 Scan-code translation is one combinational sub-module, ps2_ascii_map (9-bit code in, 8-bit ascii and valid out).
REQ-035 Queue storage is registers; no RAM inference is required.

Verification
REQ-036 Toggle ps2_key with pressed=1, code 0x1C -> one PRESENT with ascii 0x61, released 0; pulse rx_read_i -> GAP 1 cycle, IDLE, level 0.
REQ-037 Set joy_numpad to 0x005 in one cycle -> events "1" press, then "3" press, in order; then clear to 0 -> "1" release, "3" release.
REQ-038 PS/2 code 0x5A and joy bit 9 change in the same cycle -> queue order 0x0A first, then "0".
REQ-039 Never assert rx_read_i and inject 9 events with depth 8 -> level_o 8, overflow_o 1, first 8 events delivered intact afterward.
REQ-040 Code 0x76 (unmapped) -> no event, level 0; extended 0x15A -> 0x0A event.
REQ-041 Assert reset during PRESENT with 3 queued -> rx_data_ready_o 0 immediately, level 0, no event after release while inputs are static.

Source files
------------

// File: rtl/vp_kbd_pkg.sv
// vp_kbd_pkg: shared event type, output FSM states and special character codes
package vp_kbd_pkg;
    typedef struct packed {
        logic       released;
        logic [7:0] ascii;
    } kbd_evt_t;

    typedef enum logic [1:0] {IDLE, PRESENT, GAP} sched_state_t;

    localparam logic [7:0] ASCII_DC1 = 8'h11;
    localparam logic [7:0] ASCII_DC2 = 8'h12;
    localparam logic [7:0] ASCII_LF  = 8'h0A;
    localparam logic [7:0] ASCII_BS  = 8'h08;

    // Pad bits 0..8 are "1".."9", bit 9 is "0"
    function automatic logic [7:0] pad_ascii(input logic [3:0] idx);
        return (idx == 4'd9) ? 8'h30 : 8'h31 + {4'b0, idx};
    endfunction
endpackage

// File: rtl/ps2_ascii_map.sv
// ps2_ascii_map: set-2 scan code to character translation, extended bit ignored
module ps2_ascii_map
    import vp_kbd_pkg::*;
(
    input  logic [8:0] code,
    output logic [7:0] ascii,
    output logic       valid
);
    // Lookup table of supported keys; anything else is reported invalid
    always_comb begin
        ascii = 8'h00;
        valid = 1'b1;
        case (code[7:0])
            8'h16: ascii = "1";
            8'h1E: ascii = "2";
            8'h26: ascii = "3";
            8'h25: ascii = "4";
            8'h2E: ascii = "5";
            8'h36: ascii = "6";
            8'h3D: ascii = "7";
            8'h3E: ascii = "8";
            8'h46: ascii = "9";
            8'h45: ascii = "0";
            8'h1C: ascii = "a";
            8'h32: ascii = "b";
            8'h21: ascii = "c";
            8'h23: ascii = "d";
            8'h24: ascii = "e";
            8'h2B: ascii = "f";
            8'h34: ascii = "g";
            8'h33: ascii = "h";
            8'h43: ascii = "i";
            8'h3B: ascii = "j";
            8'h42: ascii = "k";
            8'h4B: ascii = "l";
            8'h3A: ascii = "m";
            8'h31: ascii = "n";
            8'h44: ascii = "o";
            8'h4D: ascii = "p";
            8'h15: ascii = "q";
            8'h2D: ascii = "r";
            8'h1B: ascii = "s";
            8'h2C: ascii = "t";
            8'h3C: ascii = "u";
            8'h2A: ascii = "v";
            8'h1D: ascii = "w";
            8'h22: ascii = "x";
            8'h35: ascii = "y";
            8'h1A: ascii = "z";
            8'h29: ascii = " ";
            8'h79: ascii = "+";
            8'h7B: ascii = "-";
            8'h7C: ascii = "*";
            8'h4A: ascii = "/";
            8'h55: ascii = "=";
            8'h1F: ascii = ASCII_DC1;
            8'h27: ascii = ASCII_DC2;
            8'h5A: ascii = ASCII_LF;
            8'h66: ascii = ASCII_BS;
            default: valid = 1'b0;
        endcase
    end
endmodule

// File: rtl/kbd_event_sched.sv
// kbd_event_sched: merges PS/2 and numpad events into a FIFO presented to the keymap
module kbd_event_sched
    import vp_kbd_pkg::*;
#(
    parameter int FIFO_DEPTH = 8
) (
    input  logic        clk_sys,
    input  logic        reset,
    input  logic [10:0] ps2_key,
    input  logic [9:0]  joy_numpad,
    output logic        rx_data_ready_o,
    output logic [7:0]  rx_ascii_o,
    output logic        rx_released_o,
    input  logic        rx_read_i,
    output logic        overflow_o,
    output logic [4:0]  level_o
);
    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [4:0] DEPTH = 5'(FIFO_DEPTH);

    kbd_evt_t      mem [FIFO_DEPTH];
    logic [AW-1:0] wp, rp;
    logic          ps2_prev;
    logic [9:0]    joy_prev, pending;
    logic [3:0]    sel;
    logic [7:0]    map_ascii;
    logic          map_valid;
    sched_state_t  state;

    ps2_ascii_map u_map (.code(ps2_key[8:0]), .ascii(map_ascii), .valid(map_valid));

    logic     ps2_enq, joy_enq, push, pop;
    kbd_evt_t enq_evt;
    kbd_evt_t head;

    // Lowest pending pad bit wins service
    always_comb begin
        sel = 4'd0;
        for (int i = 9; i >= 0; i--)
            if (pending[i]) sel = 4'(i);
    end

    // PS/2 takes the single enqueue slot; the pad waits for a free cycle
    always_comb begin
        ps2_enq = (ps2_key[10] ^ ps2_prev) & map_valid;
        joy_enq = ~ps2_enq & (|pending);
        enq_evt = ps2_enq ? kbd_evt_t'{~ps2_key[9], map_ascii}
                          : kbd_evt_t'{~joy_numpad[sel], pad_ascii(sel)};
        push    = (ps2_enq | joy_enq) & (level_o != DEPTH);
        pop     = (state == PRESENT) & rx_read_i;
        head    = mem[rp];
    end

    // Edge detection, pending mask, pointers, occupancy and sticky overflow
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            ps2_prev   <= ps2_key[10];
            joy_prev   <= joy_numpad;
            pending    <= '0;
            wp         <= '0;
            rp         <= '0;
            level_o    <= '0;
            overflow_o <= 1'b0;
        end else begin
            ps2_prev   <= ps2_key[10];
            joy_prev   <= joy_numpad;
            pending    <= (pending & ~(joy_enq ? (10'd1 << sel) : 10'd0)) | (joy_numpad ^ joy_prev);
            wp         <= push ? wp + 1'b1 : wp;
            rp         <= pop ? rp + 1'b1 : rp;
            level_o    <= level_o + {4'b0, push} - {4'b0, pop};
            overflow_o <= overflow_o | ((ps2_enq | joy_enq) & ~push);
        end
    end

    // Queue storage, written only when an event is accepted
    always_ff @(posedge clk_sys) begin
        if (push) mem[wp] <= enq_evt;
    end

    // Output handshake: present head, wait for read, then one idle gap cycle
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            state           <= IDLE;
            rx_data_ready_o <= 1'b0;
            rx_ascii_o      <= 8'h00;
            rx_released_o   <= 1'b0;
        end else begin
            case (state)
                IDLE: if (level_o != 5'd0) begin
                    state           <= PRESENT;
                    rx_data_ready_o <= 1'b1;
                    rx_ascii_o      <= head.ascii;
                    rx_released_o   <= head.released;
                end
                PRESENT: if (rx_read_i) begin
                    state           <= GAP;
                    rx_data_ready_o <= 1'b0;
                    rx_ascii_o      <= 8'h00;
                    rx_released_o   <= 1'b0;
                end
                GAP: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_kbd_event_sched.sv
// tb_kbd_event_sched: scoreboard bench for the keyboard event scheduler
module tb_kbd_event_sched;
    logic        clk_sys = 1'b0;
    logic        reset = 1'b1;
    logic [10:0] ps2_key = '0;
    logic [9:0]  joy_numpad = '0;
    logic        rx_read_i = 1'b0;
    logic        rx_data_ready_o, rx_released_o, overflow_o;
    logic [7:0]  rx_ascii_o;
    logic [4:0]  level_o;

    int n_checks = 0;
    int n_errors = 0;
    logic [8:0] exp_q [$];

    kbd_event_sched #(.FIFO_DEPTH(8)) dut (
        .clk_sys(clk_sys), .reset(reset), .ps2_key(ps2_key), .joy_numpad(joy_numpad),
        .rx_data_ready_o(rx_data_ready_o), .rx_ascii_o(rx_ascii_o),
        .rx_released_o(rx_released_o), .rx_read_i(rx_read_i),
        .overflow_o(overflow_o), .level_o(level_o)
    );

    always #5 clk_sys = ~clk_sys;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_sys);
        #1;
    endtask

    task automatic ps2_send(input logic [8:0] code, input logic pressed);
        ps2_key = {~ps2_key[10], pressed, code};
        tick();
    endtask

    // Wait for the head, check it stays put, read it, then check the gap and idle cycles
    task automatic consume(input string tag);
        logic [8:0] exp;
        int i;
        exp = exp_q.pop_front();
        for (i = 0; i < 20 && !rx_data_ready_o; i++) tick();
        if (!rx_data_ready_o) begin
            check({tag, "_timeout"}, 0, 1);
            return;
        end
        check({tag, "_evt"}, {rx_released_o, rx_ascii_o}, exp);
        tick();
        check({tag, "_stable"}, {rx_data_ready_o, rx_released_o, rx_ascii_o}, {1'b1, exp});
        rx_read_i = 1'b1;
        tick();
        rx_read_i = 1'b0;
        check({tag, "_gap"}, rx_data_ready_o, 0);
        tick();
        check({tag, "_idle"}, rx_data_ready_o, 0);
    endtask

    task automatic drain(input string tag);
        while (exp_q.size() > 0) consume(tag);
    endtask

    initial begin
        tick();
        check("rst_outs", {rx_data_ready_o, rx_ascii_o, rx_released_o, overflow_o, level_o}, 0);
        tick();
        reset = 1'b0;
        repeat (3) tick();
        check("post_rst_level", level_o, 0);
        check("post_rst_rdy", rx_data_ready_o, 0);

        ps2_send(9'h01C, 1'b1);
        exp_q.push_back({1'b0, 8'h61});
        drain("ps2_a");
        check("ps2_a_level", level_o, 0);

        ps2_send(9'h029, 1'b0);
        exp_q.push_back({1'b1, 8'h20});
        drain("ps2_space_rel");

        joy_numpad = 10'h005;
        tick();
        exp_q.push_back({1'b0, 8'h31});
        exp_q.push_back({1'b0, 8'h33});
        drain("joy_press");
        joy_numpad = 10'h000;
        tick();
        exp_q.push_back({1'b1, 8'h31});
        exp_q.push_back({1'b1, 8'h33});
        drain("joy_rel");

        joy_numpad = 10'h200;
        ps2_send(9'h05A, 1'b1);
        exp_q.push_back({1'b0, 8'h0A});
        exp_q.push_back({1'b0, 8'h30});
        drain("prio");
        joy_numpad = 10'h000;
        tick();
        exp_q.push_back({1'b1, 8'h30});
        drain("joy0_rel");

        ps2_send(9'h01C, 1'b1);
        for (int i = 0; i < 20 && !rx_data_ready_o; i++) tick();
        check("simul_head", {rx_data_ready_o, rx_ascii_o}, {1'b1, 8'h61});
        rx_read_i = 1'b1;
        ps2_send(9'h032, 1'b1);
        rx_read_i = 1'b0;
        check("simul_level", level_o, 1);
        exp_q.push_back({1'b0, 8'h62});
        drain("simul_b");

        begin
            logic [7:0] codes [9] = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33, 8'h43};
            logic [7:0] chars [9] = '{8'h61, 8'h62, 8'h63, 8'h64, 8'h65, 8'h66, 8'h67, 8'h68, 8'h69};
            for (int i = 0; i < 9; i++) begin
                ps2_send({1'b0, codes[i]}, 1'b1);
                if (i < 8) exp_q.push_back({1'b0, chars[i]});
            end
        end
        repeat (2) tick();
        check("ovf_level", level_o, 8);
        check("ovf_flag", overflow_o, 1);
        drain("ovf_drain");
        check("ovf_sticky", overflow_o, 1);

        ps2_send(9'h076, 1'b1);
        repeat (4) tick();
        check("unmapped_level", level_o, 0);
        check("unmapped_rdy", rx_data_ready_o, 0);
        ps2_send(9'h15A, 1'b1);
        exp_q.push_back({1'b0, 8'h0A});
        drain("ext_lf");

        ps2_send(9'h016, 1'b1);
        ps2_send(9'h01E, 1'b1);
        ps2_send(9'h026, 1'b1);
        for (int i = 0; i < 20 && !rx_data_ready_o; i++) tick();
        check("rst_mid_rdy_before", rx_data_ready_o, 1);
        reset = 1'b1;
        #1;
        check("rst_mid_rdy", rx_data_ready_o, 0);
        check("rst_mid_level", level_o, 0);
        check("rst_mid_ovf", overflow_o, 0);
        tick();
        reset = 1'b0;
        begin
            logic seen;
            seen = 1'b0;
            for (int i = 0; i < 10; i++) begin
                tick();
                seen |= rx_data_ready_o | (level_o != 0);
            end
            check("rst_mid_quiet", seen, 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
